// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchroniser, debounce FSM, press pulse, pending flag and press counter
// Optional auto-repeat while held: define KEY_REPEAT_EN.
`timescale 1ns/1ps
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 20,
   parameter int REPEAT_DELAY    = 10000000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic       key_clk,
   input  logic       keyrst,
   input  logic       key_in,
   input  logic       key_clr,
   output logic       key_level,
   output logic       key_press,
   output logic       key_pending,
   output logic [7:0] key_count
);

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   if (DEBOUNCE_CYCLES < 2 || (longint'(1) << CNT_WIDTH) <= longint'(DEBOUNCE_CYCLES) ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("key_debounce: invalid parameter set");
   end

   state_t               r_state;
   logic                 r_s1;
   logic                 r_s2;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_level;
   logic                 r_press;
   logic                 r_pending;
   logic [7:0]           r_count;
   logic                 w_rep_fire;

`ifdef KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] r_rcnt;
   logic             r_rep_first;   // still timing the initial delay rather than the period

   assign w_rep_fire = (r_state == PRESSED) && r_s2 &&
                       (r_rcnt == (r_rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST));

   always_ff @(posedge key_clk or posedge keyrst) begin
      if (keyrst) begin
         r_rcnt      <= '0;
         r_rep_first <= 1'b1;
      end else if (r_state != PRESSED || !r_s2) begin
         r_rcnt      <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_fire) begin
         r_rcnt      <= '0;
         r_rep_first <= 1'b0;
      end else begin
         r_rcnt <= r_rcnt + 1'b1;
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   always_ff @(posedge key_clk or posedge keyrst) begin
      if (keyrst) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_pending <= 1'b0;
         r_count   <= 8'h00;
      end else begin
         r_s1    <= key_in;
         r_s2    <= r_s1;
         r_press <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_s2) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!r_s2) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= PRESSED;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!r_s2) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= CNT_ONE;
               end else if (w_rep_fire) begin
                  r_press <= 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (r_s2) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= IDLE;
                  r_level <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
         // Pending and count follow the registered pulse, so a clear in the pulse cycle loses to the set.
         if (r_press) begin
            r_pending <= 1'b1;
            r_count   <= r_count + 8'd1;
         end else if (key_clr) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign key_level   = r_level;
   assign key_press   = r_press;
   assign key_pending = r_pending;
   assign key_count   = r_count;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce with a sample-window reference model
`timescale 1ns/1ps
module tb_key_debounce;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic       key_clk = 1'b0;
   logic       keyrst  = 1'b1;
   logic       key_in  = 1'b0;
   logic       key_clr = 1'b0;
   logic       key_level;
   logic       key_press;
   logic       key_pending;
   logic [7:0] key_count;

   int errors = 0;
   int checks = 0;

   key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .CNT_WIDTH       (4),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .key_clk     (key_clk),
      .keyrst      (keyrst),
      .key_in      (key_in),
      .key_clr     (key_clr),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_pending (key_pending),
      .key_count   (key_count)
   );

   always #5 key_clk = ~key_clk;

   // Reference: level flips once the last D synchronised samples all disagree with it.
   bit         hist[$];
   bit         s2h[$];
   bit         m_level, m_press, m_pending;
   logic [7:0] m_count;
   int         hold_start, edge_no;
   int         dut_pulses, mdl_pulses, last_press_edge;

   task automatic model_reset();
      hist.delete();
      s2h.delete();
      m_level = 0; m_press = 0; m_pending = 0; m_count = 8'h00;
      hold_start = -1; edge_no = 0;
   endtask

   task automatic model_edge(input bit kin, input bit clr);
      bit s2, flip, fire;
      s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(kin);
      s2h.push_back(s2);
      flip = (s2h.size() >= D);
      for (int j = 0; j < D; j++)
         if (flip && s2h[s2h.size()-1-j] == m_level) flip = 0;
      fire = 0;
      if (m_press) begin
         m_pending = 1;
         m_count   = m_count + 8'd1;
      end else if (clr) begin
         m_pending = 0;
      end
      if (flip) begin
         m_level    = !m_level;
         fire       = m_level;
         hold_start = m_level ? edge_no : -1;
      end else if (m_level) begin
         if (!s2) hold_start = -1;
         else if (hold_start < 0) hold_start = edge_no;
`ifdef KEY_REPEAT_EN
         else begin
            int d;
            d = edge_no - hold_start;
            if (d == RD || (d > RD && (d - RD) % RP == 0)) fire = 1;
         end
`endif
      end
      m_press = fire;
      if (fire) mdl_pulses++;
      edge_no++;
   endtask

   task automatic step(input bit kin, input bit clr);
      key_in  = kin;
      key_clr = clr;
      @(posedge key_clk);
      model_edge(kin, clr);
      @(negedge key_clk);
      if (key_press === 1'b1) begin
         dut_pulses++;
         last_press_edge = edge_no - 1;
      end
   endtask

   task automatic do_reset();
      key_in  = 0;
      key_clr = 0;
      keyrst  = 1;
      @(negedge key_clk);
      @(negedge key_clk);
      keyrst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      key_in = 1;
      keyrst = 1;
      @(negedge key_clk);
      @(negedge key_clk);
      checks++; if (key_level !== 1'b0)   begin errors++; $display("FAIL reset_level: got %b want 0", key_level); end
      checks++; if (key_press !== 1'b0)   begin errors++; $display("FAIL reset_press: got %b want 0", key_press); end
      checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", key_pending); end
      checks++; if (key_count !== 8'h00)  begin errors++; $display("FAIL reset_count: got %h want 00", key_count); end
      do_reset();
   endtask

   task automatic test_clean_press();
      do_reset();
      for (int e = 0; e < 18; e++) begin
         step(e >= 10, 0);
         checks++; if (key_press !== (e == 15)) begin errors++; $display("FAIL clean_press edge %0d: got %b want %b", e, key_press, (e == 15)); end
         checks++; if (key_level !== (e >= 15)) begin errors++; $display("FAIL clean_level edge %0d: got %b want %b", e, key_level, (e >= 15)); end
      end
      checks++; if (key_count !== 8'h01)  begin errors++; $display("FAIL clean_count: got %h want 01", key_count); end
      checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL clean_pending: got %b want 1", key_pending); end
   endtask

   task automatic test_release_bounce();
      int p0;
      p0 = dut_pulses;
      for (int e = 18; e < 34; e++) begin
         step((e >= 20 && e < 24), 0);
         checks++; if (key_level !== (e < 29)) begin errors++; $display("FAIL release_level edge %0d: got %b want %b", e, key_level, (e < 29)); end
      end
      checks++; if (dut_pulses != p0) begin errors++; $display("FAIL release_pulses: got %0d want 0", dut_pulses - p0); end
   endtask

   task automatic test_bounce();
      bit pat[$] = '{0,0,1,1,1,0,0,1,1,0,0,0,0,0,0,0,0};
      do_reset();
      foreach (pat[i]) begin
         step(pat[i], 0);
         checks++; if (key_press !== 1'b0 || key_level !== 1'b0) begin
            errors++; $display("FAIL bounce step %0d: press/level %b/%b want 0/0", i, key_press, key_level);
         end
      end
      checks++; if (key_count !== 8'h00) begin errors++; $display("FAIL bounce_count: got %h want 00", key_count); end
   endtask

   task automatic test_pending_clear();
      int n;
      do_reset();
      n = 0;
      while (key_press !== 1'b1 && n < 20) begin step(1, 0); n++; end
      checks++; if (key_press !== 1'b1) begin errors++; $display("FAIL pend_press_timeout: got %b want 1", key_press); end
      for (int i = 0; i < 4; i++) step(1, 0);
      checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL pend_set: got %b want 1", key_pending); end
      step(1, 1);
      checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b want 0", key_pending); end
      step(1, 1);
      checks++; if (key_pending !== 1'b0) begin errors++; $display("FAIL pend_clear_idle: got %b want 0", key_pending); end
      for (int i = 0; i < 8; i++) step(0, 0);
      for (int i = 0; i < 6; i++) step(1, 0);
      checks++; if (key_press !== 1'b1) begin errors++; $display("FAIL pend_second_press: got %b want 1", key_press); end
      step(1, 1);
      checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL pend_set_wins: got %b want 1", key_pending); end
      step(1, 0);
      checks++; if (key_pending !== 1'b1) begin errors++; $display("FAIL pend_hold: got %b want 1", key_pending); end
      checks++; if (key_count !== 8'h02)  begin errors++; $display("FAIL pend_count: got %h want 02", key_count); end
   endtask

   task automatic test_wrap();
      int p0;
      do_reset();
      p0 = dut_pulses;
      for (int k = 0; k < 256; k++) begin
         for (int i = 0; i < 6; i++) step(1, 0);
         for (int i = 0; i < 6; i++) step(0, 0);
         if (k == 254) begin
            checks++; if (key_count !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h want ff", key_count); end
         end
      end
      checks++; if (key_count !== 8'h00)      begin errors++; $display("FAIL wrap_00: got %h want 00", key_count); end
      checks++; if (key_count !== m_count)    begin errors++; $display("FAIL wrap_model: got %h want %h", key_count, m_count); end
      checks++; if (dut_pulses - p0 != 256)   begin errors++; $display("FAIL wrap_pulses: got %0d want 256", dut_pulses - p0); end
   endtask

   task automatic test_reset_mid();
      int p0;
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 0);
      for (int i = 0; i < 6; i++) step(0, 0);
      for (int i = 0; i < 4; i++) step(1, 0);
      #2 keyrst = 1;
      #1;
      checks++; if ({key_level, key_press, key_pending, key_count} !== 11'h0) begin
         errors++; $display("FAIL midreset_async: level/press/pending/count %b/%b/%b/%h want all 0", key_level, key_press, key_pending, key_count);
      end
      @(negedge key_clk);
      keyrst = 0;
      model_reset();
      p0 = dut_pulses;
      last_press_edge = -1;
      for (int i = 0; i < 10; i++) step(1, 0);
      checks++; if (dut_pulses - p0 != 1) begin errors++; $display("FAIL midreset_pulses: got %0d want 1", dut_pulses - p0); end
      checks++; if (last_press_edge != 5) begin errors++; $display("FAIL midreset_latency: got edge %0d want 5", last_press_edge); end
   endtask

   task automatic test_repeat();
      int p0;
      do_reset();
      p0 = dut_pulses;
      for (int i = 0; i < 26; i++) step(1, 0);
      step(0, 0);
`ifdef KEY_REPEAT_EN
      checks++; if (key_count !== 8'd6)  begin errors++; $display("FAIL repeat_count: got %0d want 6", key_count); end
`else
      checks++; if (key_count !== 8'd1)  begin errors++; $display("FAIL repeat_count: got %0d want 1", key_count); end
`endif
      checks++; if (dut_pulses - p0 != mdl_pulses) begin errors++; $display("FAIL repeat_model: got %0d pulses want %0d", dut_pulses - p0, mdl_pulses); end
   endtask

   task automatic test_random();
      int  len;
      bit  v, c;
      do_reset();
      v = 0;
      for (int r = 0; r < 60; r++) begin
         v   = !v;
         len = $urandom_range(1, 14);
         for (int i = 0; i < len; i++) begin
            c = ($urandom_range(0, 7) == 0);
            step(v, c);
            checks++;
            if (key_level !== m_level || key_press !== m_press || key_pending !== m_pending || key_count !== m_count) begin
               errors++;
               $display("FAIL random edge %0d: level/press/pending/count %b/%b/%b/%h want %b/%b/%b/%h",
                        edge_no - 1, key_level, key_press, key_pending, key_count, m_level, m_press, m_pending, m_count);
            end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      dut_pulses = 0;
      mdl_pulses = 0;
      last_press_edge = -1;
      model_reset();
      test_reset();
      test_clean_press();
      test_release_bounce();
      test_bounce();
      test_pending_clear();
      test_wrap();
      test_reset_mid();
      mdl_pulses = 0;
      test_repeat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounced push-button front end for the memory-mapped IO subsystem.
- Sits directly upstream of the LED output peripheral: its one-cycle `key_press` pulse drives that peripheral's `ledwrite` input, so LEDs update once per physical press.
- Also exposes a sticky pending flag and a press counter that MemOrIO can read back.
- Flow: synchronises the raw board button, filters bounce with a counter-based FSM, then produces level, pulse, pending and count outputs.

Parameters:
- DEBOUNCE_CYCLES, 500000, clock cycles the synchronised input must stay stable before a press/release is accepted; must be >= 2.
- CNT_WIDTH, 20, width of the debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 10000000, cycles held in PRESSED before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (used only with KEY_REPEAT_EN).

Ports:
- key_clk  input  1  single clock (cpu_clk); all logic on its rising edge.
- keyrst  input  1  reset; asynchronous, active-high.
- key_in  input  1  raw button from the board pin; active-high; asynchronous to key_clk.
- key_clr  input  1  one-cycle clear of key_pending (MemOrIO read strobe, already ANDed with chip select).
- key_level  output  1  debounced button level.
- key_press  output  1  one-cycle pulse per accepted press; feeds ledwrite.
- key_pending  output  1  sticky flag, set by key_press, cleared by key_clr.
- key_count  output  8  number of accepted press pulses, wraps modulo 256.

Behaviour:
- Reset (keyrst high, any time, asynchronous):
  - sync flops s1, s2 = 0.
  - state = IDLE, cnt = 0.
  - key_level, key_press, key_pending = 0; key_count = 8'h00.
- Synchroniser: s1 <= key_in, s2 <= s1. The FSM sees only s2.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states and transitions:
  - IDLE (released, stable):
    - s2 = 1 -> PRESS_WAIT, cnt <= 1.
    - otherwise stay, cnt = 0.
  - PRESS_WAIT:
    - s2 = 0 -> IDLE, cnt <= 0.
    - s2 = 1 and cnt == DEBOUNCE_CYCLES-1 -> PRESSED; key_level <= 1; key_press <= 1 for exactly one cycle; cnt <= 0.
    - otherwise cnt <= cnt + 1.
  - PRESSED (held, stable):
    - s2 = 0 -> RELEASE_WAIT, cnt <= 1.
    - otherwise stay.
  - RELEASE_WAIT:
    - s2 = 1 -> PRESSED, cnt <= 0, no new pulse.
    - s2 = 0 and cnt == DEBOUNCE_CYCLES-1 -> IDLE; key_level <= 0; cnt <= 0.
    - otherwise cnt <= cnt + 1.
- Latency: if key_in is first sampled high at edge N and stays high, key_press is high during the cycle after edge N+DEBOUNCE_CYCLES+1. key_level rises on the same edge. Release latency is symmetric.
- Glitch rejection: any s2 glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse and no change in key_level.
- Count: key_count increments by 1 on every key_press pulse; 8'hFF wraps to 8'h00.
- Pending:
  - key_pending <= 1 on a key_press pulse.
  - key_pending <= 0 on key_clr.
  - key_press and key_clr in the same cycle: set wins, key_pending stays 1.
  - key_clr while key_pending = 0: no effect.
- Reset mid-debounce: all progress is discarded. If the button is still held after reset deasserts, a full debounce runs and one new press is generated.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A repeat counter runs while the FSM is in PRESSED.
  - After REPEAT_DELAY cycles in PRESSED, one extra key_press pulse is emitted; then one pulse every REPEAT_PERIOD cycles while the FSM remains in PRESSED.
  - Each repeat pulse increments key_count and sets key_pending, exactly like a real press.
  - The repeat counter resets on leaving PRESSED. A bounce into RELEASE_WAIT that returns to PRESSED restarts the REPEAT_DELAY timing.
- Undefined: exactly one pulse per accepted press; REPEAT_DELAY and REPEAT_PERIOD are ignored; no repeat logic is synthesised.

Test Plan (bench uses DEBOUNCE_CYCLES=4; with KEY_REPEAT_EN, REPEAT_DELAY=8 and REPEAT_PERIOD=3):
- Clean press: key_in 0->1 sampled at edge 10, held -> key_press high only in the cycle after edge 15; key_level 1 from edge 15; key_count 0->1; key_pending 1.
- Bounce: key_in pulses high for 3 cycles, low 2, high 2, then low -> no key_press; key_level stays 0; key_count stays 0.
- Release bounce: while PRESSED, key_in low for 2 cycles then high -> key_level stays 1, no second pulse. Then low for 10 cycles -> key_level 0 at 4 cycles after s2 falls.
- Pending/clear: press, key_clr asserted 5 cycles later -> key_pending 0. Press pulse and key_clr in the same cycle -> key_pending 1.
- Wrap and reset: 256 clean presses -> key_count back to 8'h00. Assert keyrst midway through PRESS_WAIT -> all outputs 0 immediately. Button held through reset release -> exactly one press 6 cycles after release.
- KEY_REPEAT_EN: hold the button 20 cycles past key_level rising -> pulses at PRESSED+0, +8, +11, +14, +17, +20; key_count = 6. Without the macro, same stimulus -> key_count = 1.
